aes_pipe_ctrl: RTL and testbench

Flow and key-sequencing controller for the fixed-latency AES-256 core on the MM2S→S2MM path. It owns the MM2S `tready` and reserves output-FIFO space by credit, so the core's pipeline can never overrun the S2MM FIFO. It generates the FIFO write strobe and `tlast` with exactly the core's latency. It also swaps the cipher key safely: only at a frame boundary, and only after the pipeline has fully drained.

---
 rtl/aes_pipe_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_aes_pipe_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// aes_pipe_ctrl
//
// Flow and key-sequencing controller for a fixed-latency AES-256 core sitting
// between the MM2S stream and the S2MM output FIFO.
//   * Owns MM2S tready and reserves output-FIFO space by credit, so beats that
//     are already in the core can never overrun the FIFO.
//   * Produces the FIFO write strobe and tlast exactly C_PIPE_LAT cycles after
//     the launch into the core.
//   * Swaps the cipher key only at a frame boundary, and only once the pipeline
//     has fully drained.
//
// Ports
//   m_axi_mm2s_aclk  sole clock
//   axi_resetn       asynchronous active-low reset
//   in_tvalid/in_tlast/in_tready  MM2S stream handshake (in_tready is comb.)
//   pipe_launch      accepted beat; loads the core input register
//   out_wr_en/out_last  FIFO write strobe and tlast, aligned to core output
//   fifo_rd          S2MM FIFO pop; returns one credit
//   eof_full         EOF FIFO prog-full; holds off new beats
//   key_wr_req/key_wr_data/key_wr_ack  key change handshake
//   aes_key          registered key to the core
//   key_busy         controller is draining or loading a key
//   credit_cnt/inflight_cnt  debug counters
//   ctrl_err         sticky credit-overflow flag
// -----------------------------------------------------------------------------
module aes_pipe_ctrl #(
    parameter int C_PIPE_LAT   = 30,
    parameter int C_FIFO_DEPTH = 256,
    parameter int C_CNT_WIDTH  = 9,
    parameter int C_KEY_WIDTH  = 256
) (
    input  logic                   m_axi_mm2s_aclk,
    input  logic                   axi_resetn,
    input  logic                   in_tvalid,
    input  logic                   in_tlast,
    output logic                   in_tready,
    output logic                   pipe_launch,
    output logic                   out_wr_en,
    output logic                   out_last,
    input  logic                   fifo_rd,
    input  logic                   eof_full,
    input  logic                   key_wr_req,
    input  logic [C_KEY_WIDTH-1:0] key_wr_data,
    output logic                   key_wr_ack,
    output logic [C_KEY_WIDTH-1:0] aes_key,
    output logic                   key_busy,
    output logic [C_CNT_WIDTH-1:0] credit_cnt,
    output logic [C_CNT_WIDTH-1:0] inflight_cnt,
    output logic                   ctrl_err
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    localparam logic [C_CNT_WIDTH-1:0] CREDIT_FULL = C_CNT_WIDTH'(C_FIFO_DEPTH);
    localparam logic [C_CNT_WIDTH-1:0] CNT_ONE     = C_CNT_WIDTH'(1);

    state_t                 state;
    logic [C_CNT_WIDTH-1:0] credit_q;
    logic [C_CNT_WIDTH-1:0] inflight_q;
    logic [C_KEY_WIDTH-1:0] aes_key_q;
    logic                   key_ack_q;
    logic                   err_q;
    logic                   sof_q;
    logic [C_PIPE_LAT-1:0]  dl_wr;
    logic [C_PIPE_LAT-1:0]  dl_last;
    logic                   key_pend;

    // A request is ignored during the ack cycle so the requester can drop it
    // there without triggering a second swap.
    assign key_pend = key_wr_req & ~key_ack_q;

    // A pending key request at a frame boundary stops the next frame from
    // starting; mid-frame it is deferred until the frame's last beat.
    assign in_tready = (state == ST_RUN) & (credit_q != '0) & ~eof_full
                     & ~(key_pend & sof_q);
    assign pipe_launch = in_tvalid & in_tready;

    assign out_wr_en    = dl_wr[C_PIPE_LAT-1];
    assign out_last     = dl_last[C_PIPE_LAT-1];
    assign key_wr_ack   = key_ack_q;
    assign aes_key      = aes_key_q;
    assign key_busy     = (state != ST_RUN);
    assign credit_cnt   = credit_q;
    assign inflight_cnt = inflight_q;
    assign ctrl_err     = err_q;

    // Delay line mirroring the core latency.
    // NOTE: this shift register is reset on purpose (unlike a data RAM): beats
    // in flight at reset must never produce a FIFO write afterwards.
    always_ff @(posedge m_axi_mm2s_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            dl_wr   <= '0;
            dl_last <= '0;
        end else begin
            dl_wr[0]   <= pipe_launch;
            dl_last[0] <= pipe_launch & in_tlast;
            // NOTE: non-blocking assignments make every stage read the value
            // from before the edge, so loop order does not matter.
            for (int i = 1; i < C_PIPE_LAT; i++) begin
                dl_wr[i]   <= dl_wr[i-1];
                dl_last[i] <= dl_last[i-1];
            end
        end
    end

    // Credit counter: one credit per free FIFO entry not yet reserved.
    always_ff @(posedge m_axi_mm2s_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            credit_q <= CREDIT_FULL;
            err_q    <= 1'b0;
        end else if (pipe_launch && !fifo_rd) begin
            credit_q <= credit_q - CNT_ONE;
        end else if (fifo_rd && !pipe_launch) begin
            // A pop with no reservation outstanding is a protocol error; the
            // counter saturates instead of wrapping.
            if (credit_q == CREDIT_FULL) begin
                err_q <= 1'b1;
            end else begin
                credit_q <= credit_q + CNT_ONE;
            end
        end
    end

    // Beats currently inside the core.
    always_ff @(posedge m_axi_mm2s_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            inflight_q <= '0;
        end else if (pipe_launch && !out_wr_en) begin
            inflight_q <= inflight_q + CNT_ONE;
        end else if (out_wr_en && !pipe_launch) begin
            inflight_q <= inflight_q - CNT_ONE;
        end
    end

    // Start-of-frame tracking: next accepted beat begins a new frame.
    always_ff @(posedge m_axi_mm2s_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            sof_q <= 1'b1;
        end else if (pipe_launch) begin
            sof_q <= in_tlast;
        end
    end

    // Key sequencing FSM.
    always_ff @(posedge m_axi_mm2s_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state     <= ST_RUN;
            aes_key_q <= '0;
            key_ack_q <= 1'b0;
        end else begin
            key_ack_q <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (key_pend && sof_q) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (inflight_q == '0) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    aes_key_q <= key_wr_data;
                    key_ack_q <= 1'b1;
                    state     <= ST_RUN;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_pipe_ctrl
//
// Directed bench for aes_pipe_ctrl with default parameters (latency 30,
// 256-entry FIFO). Inputs change 2 ns after the rising edge; outputs are
// sampled in the same window, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_aes_pipe_ctrl;

    localparam int LAT   = 30;
    localparam int DEPTH = 256;
    localparam int CW    = 9;
    localparam int KW    = 256;

    logic          m_axi_mm2s_aclk = 1'b0;
    logic          axi_resetn      = 1'b0;
    logic          in_tvalid       = 1'b0;
    logic          in_tlast        = 1'b0;
    logic          in_tready;
    logic          pipe_launch;
    logic          out_wr_en;
    logic          out_last;
    logic          fifo_rd         = 1'b0;
    logic          eof_full        = 1'b0;
    logic          key_wr_req      = 1'b0;
    logic [KW-1:0] key_wr_data     = '0;
    logic          key_wr_ack;
    logic [KW-1:0] aes_key;
    logic          key_busy;
    logic [CW-1:0] credit_cnt;
    logic [CW-1:0] inflight_cnt;
    logic          ctrl_err;

    aes_pipe_ctrl #(
        .C_PIPE_LAT  (LAT),
        .C_FIFO_DEPTH(DEPTH),
        .C_CNT_WIDTH (CW),
        .C_KEY_WIDTH (KW)
    ) dut (
        .m_axi_mm2s_aclk(m_axi_mm2s_aclk),
        .axi_resetn     (axi_resetn),
        .in_tvalid      (in_tvalid),
        .in_tlast       (in_tlast),
        .in_tready      (in_tready),
        .pipe_launch    (pipe_launch),
        .out_wr_en      (out_wr_en),
        .out_last       (out_last),
        .fifo_rd        (fifo_rd),
        .eof_full       (eof_full),
        .key_wr_req     (key_wr_req),
        .key_wr_data    (key_wr_data),
        .key_wr_ack     (key_wr_ack),
        .aes_key        (aes_key),
        .key_busy       (key_busy),
        .credit_cnt     (credit_cnt),
        .inflight_cnt   (inflight_cnt),
        .ctrl_err       (ctrl_err)
    );

    always #5 m_axi_mm2s_aclk = ~m_axi_mm2s_aclk;

    // Event recorders (observation only).
    int            cyc      = 0;
    int            n_launch = 0;
    int            n_wr     = 0;
    int            n_ack    = 0;
    int            occ      = 0;
    int            launch_q[$];
    int            wr_q[$];
    logic          last_q[$];
    logic [KW-1:0] key_q[$];

    always @(posedge m_axi_mm2s_aclk) begin
        cyc <= cyc + 1;
        if (pipe_launch) begin
            launch_q.push_back(cyc);
            n_launch <= n_launch + 1;
        end
        if (out_wr_en) begin
            wr_q.push_back(cyc);
            last_q.push_back(out_last);
            key_q.push_back(aes_key);
            n_wr <= n_wr + 1;
        end
        if (key_wr_ack) n_ack <= n_ack + 1;
    end

    // Occupancy of the modelled S2MM FIFO, used to pop only real entries.
    always @(posedge m_axi_mm2s_aclk or negedge axi_resetn) begin
        if (!axi_resetn) occ <= 0;
        else             occ <= occ + int'(out_wr_en) - int'(fifo_rd);
    end

    int checks   = 0;
    int failures = 0;
    bit auto_pop = 1'b0;

    task automatic check(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; new inputs may be applied right after this returns.
    task automatic step();
        @(posedge m_axi_mm2s_aclk);
        #2;
        if (auto_pop) fifo_rd = (occ > 0);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    localparam logic [KW-1:0] K1 = {8{32'hA5A5_0001}};
    localparam logic [KW-1:0] K2 = {8{32'h3C3C_0002}};
    localparam logic [KW-1:0] K3 = {8{32'h0F0F_0003}};

    int nl0;
    int nw0;
    int wb;
    int lb;
    int ab;
    int t0;

    initial begin
        // ---------------- reset values ----------------
        steps(3);
        check("rst_credit",   credit_cnt,   256);
        check("rst_inflight", inflight_cnt, 0);
        check("rst_wr_en",    out_wr_en,    0);
        check("rst_busy",     key_busy,     0);
        check("rst_err",      ctrl_err,     0);
        check("rst_key",      aes_key,      0);
        check("rst_ack",      key_wr_ack,   0);
        check("rst_tready",   in_tready,    1);
        @(negedge m_axi_mm2s_aclk) axi_resetn = 1'b1;
        step();

        // ---------------- streaming, 4-beat frame ----------------
        auto_pop = 1'b1;
        lb = launch_q.size();
        wb = wr_q.size();
        in_tvalid = 1'b1;
        for (int b = 0; b < 4; b++) begin
            in_tlast = (b == 3);
            #1;
            if (b == 0) check("s_tready", in_tready, 1);
            step();
        end
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        steps(60);
        check("s_nwr", wr_q.size() - wb, 4);
        if (wr_q.size() - wb >= 4 && launch_q.size() - lb >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("s_lat%0d", i), wr_q[wb+i] - launch_q[lb+i], LAT);
                check($sformatf("s_last%0d", i), last_q[wb+i], (i == 3));
            end
        end
        check("s_credit",   credit_cnt,   256);
        check("s_inflight", inflight_cnt, 0);
        check("s_err",      ctrl_err,     0);

        // ---------------- credit exhaustion ----------------
        auto_pop = 1'b0;
        fifo_rd  = 1'b0;
        nl0 = n_launch;
        in_tvalid = 1'b1;
        steps(300);
        #1;
        check("c_accepted", n_launch - nl0, 256);
        check("c_tready",   in_tready,      0);
        check("c_credit",   credit_cnt,     0);
        fifo_rd = 1'b1;
        step();
        fifo_rd = 1'b0;
        steps(10);
        check("c_one_more", n_launch - nl0, 257);
        check("c_credit0",  credit_cnt,     0);
        in_tvalid = 1'b0;
        auto_pop  = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (credit_cnt == CW'(DEPTH)) break;
            step();
        end
        check("c_refill", credit_cnt, 256);
        // close the open frame with a single last beat
        in_tvalid = 1'b1;
        in_tlast  = 1'b1;
        step();
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        steps(40);
        check("c_err", ctrl_err, 0);

        // ---------------- mid-frame key request ----------------
        key_wr_data = K1;
        nl0 = n_launch;
        wb  = wr_q.size();
        ab  = n_ack;
        in_tvalid = 1'b1;
        for (int b = 1; b <= 8; b++) begin
            in_tlast   = (b == 8);
            key_wr_req = (b >= 2);
            step();
        end
        in_tlast = 1'b0;
        #1;
        check("m_blocked", in_tready,      0);
        check("m_beats",   n_launch - nl0, 8);
        for (int i = 0; i < 80; i++) begin
            step();
            if (key_wr_ack) break;
        end
        check("m_ack",       key_wr_ack,     1);
        check("m_no_extra",  n_launch - nl0, 8);
        check("m_key",       aes_key,        K1);
        check("m_nwr",       wr_q.size() - wb, 8);
        if (wr_q.size() - wb >= 8) begin
            check("m_ack_after_wr8", cyc - wr_q[wb+7], 3);
            check("m_wr8_oldkey",    key_q[wb+7],      0);
        end
        key_wr_req = 1'b0;
        in_tlast   = 1'b1;
        #1;
        check("m_tready_back", in_tready, 1);
        step();
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        check("m_ack_pulse", key_wr_ack,   0);
        check("m_ack_count", n_ack - ab,   1);
        steps(40);
        if (wr_q.size() - wb >= 9) check("m_newkey_beat", key_q[wb+8], K1);
        else                       check("m_nwr9", wr_q.size() - wb, 9);

        // ---------------- idle key request ----------------
        key_wr_data = K2;
        key_wr_req  = 1'b1;
        #1;
        check("i_t0_tready", in_tready, 0);
        check("i_t0_busy",   key_busy,  0);
        step();
        check("i_t1_busy", key_busy,   1);
        check("i_t1_ack",  key_wr_ack, 0);
        step();
        check("i_t2_busy", key_busy, 1);
        check("i_t2_key",  aes_key,  K1);
        step();
        check("i_t3_busy", key_busy,   0);
        check("i_t3_ack",  key_wr_ack, 1);
        check("i_t3_key",  aes_key,    K2);
        key_wr_req = 1'b0;
        step();
        check("i_t4_ack", key_wr_ack, 0);

        // ---------------- backpressure and simultaneous events ----------------
        auto_pop = 1'b0;
        fifo_rd  = 1'b0;
        nl0 = n_launch;
        eof_full  = 1'b1;
        in_tvalid = 1'b1;
        in_tlast  = 1'b1;
        #1;
        check("b_eof_tready", in_tready, 0);
        steps(3);
        check("b_eof_nolaunch", n_launch - nl0, 0);
        eof_full = 1'b0;
        step();
        in_tvalid = 1'b0;
        check("b_credit255", credit_cnt, 255);
        in_tvalid = 1'b1;
        fifo_rd   = 1'b1;
        step();
        in_tvalid = 1'b0;
        fifo_rd   = 1'b0;
        check("b_simul_credit", credit_cnt,     255);
        check("b_simul_launch", n_launch - nl0, 2);
        fifo_rd = 1'b1;
        step();
        fifo_rd = 1'b0;
        check("b_credit256", credit_cnt, 256);
        check("b_err0",      ctrl_err,   0);
        fifo_rd = 1'b1;
        step();
        fifo_rd = 1'b0;
        check("b_sat_credit", credit_cnt, 256);
        check("b_err1",       ctrl_err,   1);
        in_tlast = 1'b0;
        steps(40);

        // ---------------- reset during DRAIN ----------------
        key_wr_data = K3;
        in_tvalid   = 1'b1;
        for (int b = 1; b <= 10; b++) begin
            in_tlast   = (b == 10);
            key_wr_req = (b >= 2);
            step();
        end
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        steps(2);
        check("r_busy",     key_busy,     1);
        check("r_inflight", inflight_cnt, 10);
        check("r_credit",   credit_cnt,   246);
        #1 axi_resetn = 1'b0;
        #1;
        check("r_credit_rst",   credit_cnt,   256);
        check("r_inflight_rst", inflight_cnt, 0);
        check("r_busy_rst",     key_busy,     0);
        check("r_err_rst",      ctrl_err,     0);
        check("r_key_rst",      aes_key,      0);
        check("r_wr_rst",       out_wr_en,    0);
        check("r_last_rst",     out_last,     0);
        check("r_ack_rst",      key_wr_ack,   0);
        key_wr_req = 1'b0;
        nw0 = n_wr;
        t0  = cyc;
        steps(2);
        @(negedge m_axi_mm2s_aclk) axi_resetn = 1'b1;
        steps(50);
        check("r_no_wr_after", n_wr - nw0, 0);
        check("r_tready",      in_tready,  1);
        check("r_credit_end",  credit_cnt, 256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
